draw_rect_fill: RTL and testbench
=================================

# draw_rect_fill

Parametrised successor to the full-screen clear engine. It accepts a rectangle draw command through a valid/ready handshake and clips the rectangle to the screen. It then drives the SDRAM read-modify-write region interface, computing each pixel's new colour from one of four modes: solid, alpha blend, XOR, or checkerboard. It sits between the command source (CPU bridge or rasteriser) and the SDRAM interface.

## Interface
- COORD_W, 16, coordinate/range width
- COLOUR_W, 32, pixel width (ARGB8888; A = [31:24])
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels
- CHECK_LOG2, 3, checkerboard tile size = 2^CHECK_LOG2 pixels

Ports:
- clock  in  1  single system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x, cmd_y  in  COORD_W  rectangle origin (unsigned)
- cmd_w, cmd_h  in  COORD_W  rectangle size in pixels
- cmd_mode  in  2  0 solid, 1 blend, 2 xor, 3 checker
- cmd_colour_a, cmd_colour_b  in  COLOUR_W  primary and secondary colour (b used only by checker)
- busy  out  1  command in flight
- done  out  1  one-cycle pulse at command completion
- screen_start  out  1  one-cycle region launch pulse
- screen_x_min, screen_y_min, screen_x_range, screen_y_range  out  COORD_W  clipped region
- screen_x, screen_y  in  COORD_W  pixel currently addressed by the interface
- old_screen_colour  in  COLOUR_W  stored colour at that pixel
- new_screen_colour  out  COLOUR_W  colour to write at that pixel
- screen_done  in  1  one-cycle pulse when the region is complete

## Operation
- FSM states: IDLE, CLIP, LAUNCH, WAIT, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all cmd_* fields and go to CLIP.
- CLIP:
  - x_end = min(cmd_x + cmd_w, SCREEN_W). Sum computed at COORD_W+1 bits, so no wrap.
  - y_end = min(cmd_y + cmd_h, SCREEN_H), computed the same way.
  - Range = end − origin.
  - Empty region goes straight to FINISH with no screen_start. A region is empty if cmd_x ≥ SCREEN_W, cmd_y ≥ SCREEN_H, or either size is 0.
  - Otherwise register the region outputs and go to LAUNCH.
- LAUNCH: assert screen_start for one cycle, then go to WAIT.
- WAIT: hold the region outputs stable until screen_done, then go to FINISH.
- FINISH: pulse done for one cycle, then return to IDLE.
- new_screen_colour is combinational from screen_x, screen_y, old_screen_colour and the latched command. Per mode:
  - solid: colour_a.
  - xor: old ^ colour_a.
  - blend: per 8-bit channel c (R, G, B), c = (old_c·(255−α) + a_c·α + 255) >> 8, with α = colour_a[31:24]. Output alpha = 8'hFF. 17-bit intermediate. α=255 yields exactly a_c; α=0 yields exactly old_c.
  - checker: selects colour_b when screen_x[CHECK_LOG2] ^ screen_y[CHECK_LOG2] is 1, otherwise colour_a.
- Commands offered while busy are not accepted (cmd_ready=0); there is no queueing.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1.
  - busy, done and screen_start are 0.
  - Region outputs and latched fields are 0.
  - new_screen_colour evaluates to 0 (latched colour 0, mode 0).
- Handshake: a command is accepted in the cycle where cmd_valid & cmd_ready are both high.
- busy rises the cycle after acceptance and falls with done.
- Latency, non-empty region: acceptance edge → screen_start is 2 cycles (CLIP, LAUNCH).
- screen_done → done: next cycle.
- Empty region: acceptance → done in 2 cycles.
- Earliest next acceptance: the cycle after done.
- screen_done outside WAIT is ignored.
- Reset asserted mid-operation returns everything to reset values immediately. The SDRAM interface shares reset_n.

## Structure
- Shared package (draw_pkg): mode encodings (MODE_SOLID/BLEND/XOR/CHECK), ARGB channel slice constants, FSM state enum.
- One sub-module: draw_pixel_op. It is purely combinational: mode, colours, x/y, old → new. It is reused by later line and triangle engines.

## Test plan
- Reset, then solid 32'hFF00FF00 at (10,20) size 4×3 → screen_start 2 cycles after acceptance. Region (10,20,4,3). Every pixel receives FF00FF00. done one cycle after screen_done.
- Clip: (630,470) size 50×50 → region (630,470,10,10). Origin (700,0) → done with no screen_start, 2 cycles after acceptance.
- Blend, colour_a 80FF0000, old FF0000FF → new FF80007F. α=FF returns colour_a's RGB exactly; α=00 returns old RGB exactly.
- XOR 00FFFFFF applied twice over the same region → original contents restored. Checker with CHECK_LOG2=3 at (7,0) gives a; at (8,0) gives b; at (8,8) gives a.
- cmd_valid held while busy → cmd_ready=0, no second screen_start. After done, the queued command is accepted next cycle.
- reset_n pulsed low during WAIT → all outputs immediately at reset values, state IDLE. A stray screen_done afterwards produces no done.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the drawing engines: pixel modes, ARGB channel layout, FSM states
// and the per-channel alpha blend used by draw_pixel_op.
package draw_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BLEND = 2'd1;
  localparam logic [1:0] MODE_XOR   = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  localparam int unsigned CH_W     = 8;
  localparam int unsigned CH_A_LSB = 24;
  localparam int unsigned CH_R_LSB = 16;
  localparam int unsigned CH_G_LSB = 8;
  localparam int unsigned CH_B_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StClip,
    StLaunch,
    StWait,
    StFinish
  } draw_state_e;

  // The +255 bias makes alpha 0 and 255 return the old and new channel exactly.
  function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] old_c,
                                               input logic [CH_W-1:0] a_c,
                                               input logic [CH_W-1:0] alpha);
    logic [16:0] acc;
    acc = 17'(old_c) * 17'(8'hFF - alpha) + 17'(a_c) * 17'(alpha) + 17'd255;
    return 8'(acc >> 8);
  endfunction

endpackage

// File: rtl/draw_pixel_op.sv
// Combinational per-pixel colour operator: solid, alpha blend, XOR or checkerboard.
module draw_pixel_op
  import draw_pkg::*;
#(
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned COLOUR_W   = 32,
  parameter int unsigned CHECK_LOG2 = 3
) (
  input  logic [1:0]          i_mode,
  input  logic [COLOUR_W-1:0] i_colour_a,
  input  logic [COLOUR_W-1:0] i_colour_b,
  input  logic [COORD_W-1:0]  i_x,
  input  logic [COORD_W-1:0]  i_y,
  input  logic [COLOUR_W-1:0] i_old,
  output logic [COLOUR_W-1:0] o_new
);

  logic [CH_W-1:0]     w_alpha;
  logic [COLOUR_W-1:0] w_blend;
  logic                w_tile_b;
  logic                w_unused_xy;

  assign w_alpha  = i_colour_a[CH_A_LSB +: CH_W];
  assign w_tile_b = i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2];
  // Only the tile-select bit of each coordinate matters here.
  assign w_unused_xy = ^{i_x, i_y};

  always_comb begin
    w_blend = '0;
    w_blend[CH_A_LSB +: CH_W] = 8'hFF;
    w_blend[CH_R_LSB +: CH_W] = blend_ch(i_old[CH_R_LSB +: CH_W],
                                         i_colour_a[CH_R_LSB +: CH_W], w_alpha);
    w_blend[CH_G_LSB +: CH_W] = blend_ch(i_old[CH_G_LSB +: CH_W],
                                         i_colour_a[CH_G_LSB +: CH_W], w_alpha);
    w_blend[CH_B_LSB +: CH_W] = blend_ch(i_old[CH_B_LSB +: CH_W],
                                         i_colour_a[CH_B_LSB +: CH_W], w_alpha);
  end

  always_comb begin
    o_new = i_colour_a;
    unique case (i_mode)
      MODE_SOLID: o_new = i_colour_a;
      MODE_BLEND: o_new = w_blend;
      MODE_XOR:   o_new = i_old ^ i_colour_a;
      MODE_CHECK: o_new = w_tile_b ? i_colour_b : i_colour_a;
    endcase
  end

endmodule

// File: rtl/draw_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it to the screen and drives one
// read-modify-write region on the SDRAM interface with a per-pixel colour operator.
module draw_rect_fill
  import draw_pkg::*;
#(
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned COLOUR_W   = 32,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned CHECK_LOG2 = 3
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [COORD_W-1:0]  i_cmd_x,
  input  logic [COORD_W-1:0]  i_cmd_y,
  input  logic [COORD_W-1:0]  i_cmd_w,
  input  logic [COORD_W-1:0]  i_cmd_h,
  input  logic [1:0]          i_cmd_mode,
  input  logic [COLOUR_W-1:0] i_cmd_colour_a,
  input  logic [COLOUR_W-1:0] i_cmd_colour_b,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_screen_start,
  output logic [COORD_W-1:0]  o_screen_x_min,
  output logic [COORD_W-1:0]  o_screen_y_min,
  output logic [COORD_W-1:0]  o_screen_x_range,
  output logic [COORD_W-1:0]  o_screen_y_range,
  input  logic [COORD_W-1:0]  i_screen_x,
  input  logic [COORD_W-1:0]  i_screen_y,
  input  logic [COLOUR_W-1:0] i_old_screen_colour,
  output logic [COLOUR_W-1:0] o_new_screen_colour,
  input  logic                i_screen_done
);

  localparam logic [COORD_W:0] ScreenWExt = (COORD_W + 1)'(SCREEN_W);
  localparam logic [COORD_W:0] ScreenHExt = (COORD_W + 1)'(SCREEN_H);

  draw_state_e         r_state, w_state_nxt;
  logic [COORD_W-1:0]  r_x, r_y, r_w, r_h;
  logic [1:0]          r_mode;
  logic [COLOUR_W-1:0] r_colour_a, r_colour_b;
  logic [COORD_W-1:0]  r_x_min, r_y_min, r_x_range, r_y_range;

  logic [COORD_W:0]    w_x_sum, w_y_sum, w_x_end, w_y_end;
  logic                w_empty;

  // Sums carry one extra bit so a large origin + size cannot wrap below the screen edge.
  always_comb begin
    w_x_sum = {1'b0, r_x} + {1'b0, r_w};
    w_y_sum = {1'b0, r_y} + {1'b0, r_h};
    w_x_end = (w_x_sum > ScreenWExt) ? ScreenWExt : w_x_sum;
    w_y_end = (w_y_sum > ScreenHExt) ? ScreenHExt : w_y_sum;
    w_empty = ({1'b0, r_x} >= ScreenWExt) || ({1'b0, r_y} >= ScreenHExt) ||
              (r_w == '0) || (r_h == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_cmd_valid) w_state_nxt = StClip;
      StClip:   w_state_nxt = w_empty ? StFinish : StLaunch;
      StLaunch: w_state_nxt = StWait;
      StWait:   if (i_screen_done) w_state_nxt = StFinish;
      StFinish: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_mode     <= MODE_SOLID;
      r_colour_a <= '0;
      r_colour_b <= '0;
    end else if (r_state == StIdle && i_cmd_valid) begin
      r_x        <= i_cmd_x;
      r_y        <= i_cmd_y;
      r_w        <= i_cmd_w;
      r_h        <= i_cmd_h;
      r_mode     <= i_cmd_mode;
      r_colour_a <= i_cmd_colour_a;
      r_colour_b <= i_cmd_colour_b;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x_min   <= '0;
      r_y_min   <= '0;
      r_x_range <= '0;
      r_y_range <= '0;
    end else if (r_state == StClip && !w_empty) begin
      r_x_min   <= r_x;
      r_y_min   <= r_y;
      r_x_range <= COORD_W'(w_x_end - {1'b0, r_x});
      r_y_range <= COORD_W'(w_y_end - {1'b0, r_y});
    end
  end

  assign o_cmd_ready      = (r_state == StIdle);
  assign o_busy           = (r_state != StIdle);
  assign o_done           = (r_state == StFinish);
  assign o_screen_start   = (r_state == StLaunch);
  assign o_screen_x_min   = r_x_min;
  assign o_screen_y_min   = r_y_min;
  assign o_screen_x_range = r_x_range;
  assign o_screen_y_range = r_y_range;

  draw_pixel_op #(
    .COORD_W    (COORD_W),
    .COLOUR_W   (COLOUR_W),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pixel_op (
    .i_mode     (r_mode),
    .i_colour_a (r_colour_a),
    .i_colour_b (r_colour_b),
    .i_x        (i_screen_x),
    .i_y        (i_screen_y),
    .i_old      (i_old_screen_colour),
    .o_new      (o_new_screen_colour)
  );

endmodule

// File: tb/tb_draw_rect_fill.sv
// Directed bench for draw_rect_fill; the bench plays both command source and SDRAM interface.
module tb_draw_rect_fill;
  import draw_pkg::*;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [1:0]  cmd_mode;
  logic [31:0] cmd_a, cmd_b;
  logic        busy, done, screen_start, screen_done;
  logic [15:0] x_min, y_min, x_range, y_range, screen_x, screen_y;
  logic [31:0] old_colour, new_colour;

  int checks   = 0;
  int failures = 0;

  draw_rect_fill #(
    .COORD_W    (16),
    .COLOUR_W   (32),
    .SCREEN_W   (640),
    .SCREEN_H   (480),
    .CHECK_LOG2 (3)
  ) dut (
    .i_clock             (clk),
    .i_reset_n           (rst_n),
    .i_cmd_valid         (cmd_valid),
    .o_cmd_ready         (cmd_ready),
    .i_cmd_x             (cmd_x),
    .i_cmd_y             (cmd_y),
    .i_cmd_w             (cmd_w),
    .i_cmd_h             (cmd_h),
    .i_cmd_mode          (cmd_mode),
    .i_cmd_colour_a      (cmd_a),
    .i_cmd_colour_b      (cmd_b),
    .o_busy              (busy),
    .o_done              (done),
    .o_screen_start      (screen_start),
    .o_screen_x_min      (x_min),
    .o_screen_y_min      (y_min),
    .o_screen_x_range    (x_range),
    .o_screen_y_range    (y_range),
    .i_screen_x          (screen_x),
    .i_screen_y          (screen_y),
    .i_old_screen_colour (old_colour),
    .o_new_screen_colour (new_colour),
    .i_screen_done       (screen_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                         input logic [15:0] h, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_mode = mode; cmd_a = a; cmd_b = b;
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                       input logic [15:0] h, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    set_cmd(x, y, w, h, mode, a, b);
    cmd_valid = 1'b1;
    check("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Launch must appear exactly on the second cycle after the accepting edge.
  task automatic expect_launch(input logic [15:0] xm, input logic [15:0] ym,
                               input logic [15:0] xr, input logic [15:0] yr);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("start_too_early", screen_start, 0);
    @(negedge clk);
    check("start_latency", screen_start, 1);
    check("x_min", x_min, xm);
    check("y_min", y_min, ym);
    check("x_range", x_range, xr);
    check("y_range", y_range, yr);
  endtask

  task automatic probe(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] old, input logic [31:0] exp);
    @(negedge clk);
    screen_x = x; screen_y = y; old_colour = old;
    #1 check(tag, new_colour, exp);
  endtask

  task automatic finish_region();
    @(negedge clk);
    check("start_one_cycle", screen_start, 0);
    screen_done = 1'b1;
    @(posedge clk);
    #1 screen_done = 1'b0;
    @(negedge clk);
    check("done_after_screen_done", done, 1);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    check({tag, "_no_start_c1"}, screen_start, 0);
    check({tag, "_no_done_c1"}, done, 0);
    @(negedge clk);
    check({tag, "_no_start_c2"}, screen_start, 0);
    check({tag, "_done_c2"}, done, 1);
    @(negedge clk);
    check({tag, "_idle"}, cmd_ready, 1);
  endtask

  task automatic pix_case(input string tag, input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] old, input logic [31:0] exp);
    issue(16'd0, 16'd0, 16'd16, 16'd16, mode, a, b);
    expect_launch(16'd0, 16'd0, 16'd16, 16'd16);
    probe(tag, x, y, old, exp);
    finish_region();
  endtask

  logic [31:0] orig [4];
  logic [31:0] mem  [4];
  int          starts;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; screen_done = 1'b0;
    set_cmd(16'd0, 16'd0, 16'd0, 16'd0, MODE_SOLID, 32'd0, 32'd0);
    screen_x = 16'd3; screen_y = 16'd5; old_colour = 32'hDEADBEEF;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", screen_start, 0);
    check("rst_region", {x_min, y_min, x_range, y_range}, 64'd0);
    check("rst_new_colour", new_colour, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Solid fill: every pixel of the 4x3 region gets colour_a whatever was stored.
    issue(16'd10, 16'd20, 16'd4, 16'd3, MODE_SOLID, 32'hFF00FF00, 32'd0);
    expect_launch(16'd10, 16'd20, 16'd4, 16'd3);
    for (int py = 0; py < 3; py++) begin
      for (int px = 0; px < 4; px++) begin
        probe("solid_pixel", 16'(10 + px), 16'(20 + py), $urandom, 32'hFF00FF00);
      end
    end
    finish_region();

    // Clipping and empty regions.
    issue(16'd630, 16'd470, 16'd50, 16'd50, MODE_SOLID, 32'h1, 32'd0);
    expect_launch(16'd630, 16'd470, 16'd10, 16'd10);
    finish_region();
    issue(16'd700, 16'd0, 16'd5, 16'd5, MODE_SOLID, 32'h1, 32'd0);
    expect_empty("empty_x");
    issue(16'd0, 16'd480, 16'd5, 16'd5, MODE_SOLID, 32'h1, 32'd0);
    expect_empty("empty_y");
    issue(16'd5, 16'd5, 16'd0, 16'd3, MODE_SOLID, 32'h1, 32'd0);
    expect_empty("empty_w");
    issue(16'd65535, 16'd10, 16'd2, 16'd2, MODE_SOLID, 32'h1, 32'd0);
    expect_empty("empty_wrap");

    // Pixel operator vectors.
    pix_case("blend_half", MODE_BLEND, 32'h80FF0000, 32'd0, 16'd0, 16'd0, 32'hFF0000FF,
             32'hFF80007F);
    pix_case("blend_a_ff", MODE_BLEND, 32'hFF123456, 32'd0, 16'd1, 16'd0, 32'h00ABCDEF,
             32'hFF123456);
    pix_case("blend_a_00", MODE_BLEND, 32'h00123456, 32'd0, 16'd2, 16'd0, 32'h77ABCDEF,
             32'hFFABCDEF);
    pix_case("blend_a_40", MODE_BLEND, 32'h40C80000, 32'd0, 16'd3, 16'd0, 32'h00100000,
             32'hFF3E0000);
    pix_case("xor_single", MODE_XOR, 32'h00FFFFFF, 32'd0, 16'd4, 16'd4, 32'h12345678,
             32'h12CBA987);
    pix_case("check_7_0", MODE_CHECK, 32'h11111111, 32'h22222222, 16'd7, 16'd0, 32'h0,
             32'h11111111);
    pix_case("check_8_0", MODE_CHECK, 32'h11111111, 32'h22222222, 16'd8, 16'd0, 32'h0,
             32'h22222222);
    pix_case("check_8_8", MODE_CHECK, 32'h11111111, 32'h22222222, 16'd8, 16'd8, 32'h0,
             32'h11111111);
    pix_case("check_0_8", MODE_CHECK, 32'h11111111, 32'h22222222, 16'd0, 16'd8, 32'h0,
             32'h22222222);

    // XOR twice over a 2x2 region restores the stored pixels.
    orig[0] = 32'h01234567; orig[1] = 32'h89ABCDEF; orig[2] = 32'hFF000000;
    orig[3] = 32'h00FF00FF;
    for (int i = 0; i < 4; i++) mem[i] = orig[i];
    for (int pass = 0; pass < 2; pass++) begin
      issue(16'd0, 16'd0, 16'd2, 16'd2, MODE_XOR, 32'h00FFFFFF, 32'd0);
      expect_launch(16'd0, 16'd0, 16'd2, 16'd2);
      for (int i = 0; i < 4; i++) begin
        probe(pass == 0 ? "xor_pass1" : "xor_pass2", 16'(i % 2), 16'(i / 2), mem[i],
              (pass == 0) ? (orig[i] ^ 32'h00FFFFFF) : orig[i]);
        mem[i] = new_colour;
      end
      finish_region();
    end

    // cmd_valid held while busy: no second launch, second command taken after done.
    @(negedge clk);
    set_cmd(16'd1, 16'd1, 16'd1, 16'd1, MODE_SOLID, 32'h0A0A0A0A, 32'd0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 set_cmd(16'd2, 16'd2, 16'd1, 16'd1, MODE_SOLID, 32'h0B0B0B0B, 32'd0);
    starts = 0;
    @(negedge clk);
    check("held_ready_clip", cmd_ready, 0);
    starts += int'(screen_start);
    @(negedge clk);
    check("held_ready_launch", cmd_ready, 0);
    starts += int'(screen_start);
    @(negedge clk);
    check("held_ready_wait", cmd_ready, 0);
    starts += int'(screen_start);
    screen_done = 1'b1;
    @(posedge clk);
    #1 screen_done = 1'b0;
    @(negedge clk);
    check("held_done", done, 1);
    check("held_ready_finish", cmd_ready, 0);
    starts += int'(screen_start);
    check("held_single_start", 64'(starts), 1);
    @(negedge clk);
    check("held_ready_after_done", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    expect_launch(16'd2, 16'd2, 16'd1, 16'd1);
    probe("held_second_colour", 16'd2, 16'd2, 32'h0, 32'h0B0B0B0B);
    finish_region();

    // Reset during WAIT, then a stray screen_done must not produce done.
    issue(16'd100, 16'd100, 16'd2, 16'd2, MODE_SOLID, 32'h12345678, 32'd0);
    expect_launch(16'd100, 16'd100, 16'd2, 16'd2);
    @(negedge clk);
    old_colour = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", screen_start, 0);
    check("mid_rst_region", {x_min, y_min, x_range, y_range}, 64'd0);
    check("mid_rst_new_colour", new_colour, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    screen_done = 1'b1;
    @(posedge clk);
    #1 screen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_screen_done", done, 0);
      check("stray_idle", cmd_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
